// File: rtl/t06_lcd_pkg.sv
// Shared types and constants for the LCD frame engine: object codes, RGB565 colours,
// ILI9341 opcodes and the controller power-up sequence.
// Latency: n/a (types, constants and pure functions only). Backpressure: n/a.
package t06_lcd_pkg;

  typedef enum logic [2:0] {
    OBJ_EMPTY  = 3'd0,
    OBJ_HEAD   = 3'd1,
    OBJ_BODY   = 3'd2,
    OBJ_APPLE  = 3'd3,
    OBJ_BORDER = 3'd4
  } obj_t;

  typedef enum logic [2:0] {
    ST_INIT_SEND,
    ST_INIT_WAIT,
    ST_IDLE,
    ST_SCAN,
    ST_DRAW
  } state_t;

  localparam logic [15:0] COLOR_EMPTY    = 16'h0000;
  localparam logic [15:0] COLOR_HEAD     = 16'h07E0;
  localparam logic [15:0] COLOR_BODY     = 16'h03E0;
  localparam logic [15:0] COLOR_APPLE    = 16'hF800;
  localparam logic [15:0] COLOR_BORDER   = 16'hFFFF;
  localparam logic [15:0] COLOR_GAMEOVER = 16'hF800;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] ARG_RGB565  = 8'h55;
  localparam logic [7:0] ARG_MADCTL  = 8'h48;

  // One init step: byte, its D/CX level, and whether the long settle wait follows it.
  typedef struct packed {
    logic       wait_after;
    logic       dcx;
    logic [7:0] dat;
  } init_ent_t;

  localparam int INIT_LEN = 7;

  function automatic init_ent_t init_rom(input logic [2:0] idx);
    init_ent_t e;
    case (idx)
      3'd0:    e = '{wait_after: 1'b1, dcx: 1'b0, dat: CMD_SWRESET};
      3'd1:    e = '{wait_after: 1'b1, dcx: 1'b0, dat: CMD_SLPOUT};
      3'd2:    e = '{wait_after: 1'b0, dcx: 1'b0, dat: CMD_COLMOD};
      3'd3:    e = '{wait_after: 1'b0, dcx: 1'b1, dat: ARG_RGB565};
      3'd4:    e = '{wait_after: 1'b0, dcx: 1'b0, dat: CMD_MADCTL};
      3'd5:    e = '{wait_after: 1'b0, dcx: 1'b1, dat: ARG_MADCTL};
      default: e = '{wait_after: 1'b0, dcx: 1'b0, dat: CMD_DISPON};
    endcase
    return e;
  endfunction

  // Priority encode the lookup flags; during the tint redraw apples vanish.
  function automatic obj_t obj_code(input logic head, input logic body, input logic apple,
                                    input logic border, input logic tint);
    if (head)        return OBJ_HEAD;
    else if (body)   return OBJ_BODY;
    else if (apple)  return tint ? OBJ_EMPTY : OBJ_APPLE;
    else if (border) return OBJ_BORDER;
    else             return OBJ_EMPTY;
  endfunction

  function automatic logic [15:0] obj_colour(input obj_t code, input logic tint);
    case (code)
      OBJ_HEAD:   return tint ? COLOR_GAMEOVER : COLOR_HEAD;
      OBJ_BODY:   return tint ? COLOR_GAMEOVER : COLOR_BODY;
      OBJ_APPLE:  return COLOR_APPLE;
      OBJ_BORDER: return COLOR_BORDER;
      default:    return COLOR_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/t06_lcd_byte_tx.sv
// 8080 write-strobe generator: shifts one byte onto lcd_d/lcd_dcx and pulses lcd_wr.
// Latency: lcd_wr falls on the edge that accepts the byte; a byte occupies WR_LOW+WR_HIGH cycles.
// Backpressure: byte_rdy is high when idle or in the last high cycle; byte_vld&&byte_rdy launches.
// Ports: clk, rst (sync, active high); byte_dat/byte_dcx/byte_vld in, byte_rdy out;
//        lcd_wr/lcd_d/lcd_dcx drive the panel bus directly.
module t06_lcd_byte_tx #(
  parameter int WR_LOW  = 1,
  parameter int WR_HIGH = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_dat,
  input  logic       byte_dcx,
  input  logic       byte_vld,
  output logic       byte_rdy,
  output logic       lcd_wr,
  output logic [7:0] lcd_d,
  output logic       lcd_dcx
);

  logic        active_q, active_d;
  logic        high_q, high_d;
  logic        wr_q, wr_d;
  logic        dcx_q, dcx_d;
  logic [7:0]  d_q, d_d;
  logic [15:0] cnt_q, cnt_d;
  logic        fin;

  always_comb begin
    active_d = active_q;
    high_d   = high_q;
    wr_d     = wr_q;
    dcx_d    = dcx_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    // Last high cycle can hand over straight to the next byte, so back-to-back
    // bytes cost exactly WR_LOW+WR_HIGH cycles.
    fin      = active_q && high_q && (cnt_q == 16'd0);
    byte_rdy = !active_q || fin;
    if (byte_rdy) begin
      if (byte_vld) begin
        active_d = 1'b1;
        high_d   = 1'b0;
        wr_d     = 1'b0;
        cnt_d    = 16'(WR_LOW - 1);
        d_d      = byte_dat;
        dcx_d    = byte_dcx;
      end else begin
        active_d = 1'b0;
      end
    end else if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      // End of low phase: rising edge latches the byte in the panel.
      high_d = 1'b1;
      wr_d   = 1'b1;
      cnt_d  = 16'(WR_HIGH - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      high_q   <= 1'b0;
      wr_q     <= 1'b1;
      dcx_q    <= 1'b1;
      d_q      <= 8'h00;
      cnt_q    <= 16'd0;
    end else begin
      active_q <= active_d;
      high_q   <= high_d;
      wr_q     <= wr_d;
      dcx_q    <= dcx_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
    end
  end

  assign lcd_wr  = wr_q;
  assign lcd_d   = d_q;
  assign lcd_dcx = dcx_q;

endmodule

// File: rtl/t06_lcd_frame_engine.sv
// Scans a GRID_W x GRID_H cell map and redraws changed cells as CELL_PX squares on an 8080 LCD.
// Latency: cell flags sampled one cycle after x/y change; unchanged cells cost one cycle each.
// Backpressure: the engine stalls on the byte transmitter; the lookup side is never stalled.
// Ports: clk, rst (sync, active high); body/head/apple/border lookup flags for (x,y);
//        start (full-redraw pulse), game_over (level); x/y lookup address;
//        lcd_csx/lcd_dcx/lcd_wr/lcd_d panel bus; busy (not IDLE), frame_done (end-of-scan pulse).
// Build option: define T06_GAMEOVER_TINT_EN for one red-tinted full redraw on game over.
module t06_lcd_frame_engine
  import t06_lcd_pkg::*;
#(
  parameter int GRID_W    = 16,
  parameter int GRID_H    = 12,
  parameter int CELL_PX   = 20,
  parameter int X_OFF     = 0,
  parameter int Y_OFF     = 0,
  parameter int WR_LOW    = 1,
  parameter int WR_HIGH   = 1,
  parameter int INIT_WAIT = 600000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      body,
  input  logic                      head,
  input  logic                      apple,
  input  logic                      border,
  input  logic                      start,
  input  logic                      game_over,
  output logic [$clog2(GRID_W)-1:0] x,
  output logic [$clog2(GRID_H)-1:0] y,
  output logic                      lcd_csx,
  output logic                      lcd_dcx,
  output logic                      lcd_wr,
  output logic [7:0]                lcd_d,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int XW     = $clog2(GRID_W);
  localparam int YW     = $clog2(GRID_H);
  localparam int NCELL  = GRID_W * GRID_H;
  localparam int IW     = $clog2(NCELL);
  // 11 address/command bytes followed by two bytes per pixel.
  localparam int NBYTES = 11 + 2 * CELL_PX * CELL_PX;
  localparam int BW     = $clog2(NBYTES);
  localparam logic [2:0] INIT_LAST = 3'(INIT_LEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       init_idx_q, init_idx_d;
  logic [31:0]      wait_cnt_q, wait_cnt_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             full_q, full_d;
  logic             start_pend_q, start_pend_d;
  obj_t             code_q, code_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [NCELL-1:0] shadow_vld_q, shadow_vld_d;
  logic             frame_done_q, frame_done_d;
  logic             csx_q, csx_d;
  obj_t             shadow_code_q [NCELL];
  logic             shadow_we;
  logic             adv;
  logic             tint_act;

  logic       tx_vld, tx_rdy, tx_dcx;
  logic [7:0] tx_dat;

  init_ent_t     ent;
  logic [IW-1:0] cell_idx;
  logic          last_cell;
  obj_t          cell_code;
  logic [15:0]   col_s, col_e, row_s, row_e, pix;

`ifdef T06_GAMEOVER_TINT_EN
  logic tint_q, tint_d;
  logic tint_done_q, tint_done_d;
  assign tint_act = tint_q;
`else
  assign tint_act = 1'b0;
`endif

  assign ent       = init_rom(init_idx_q);
  assign cell_idx  = IW'(y_q) * IW'(GRID_W) + IW'(x_q);
  assign last_cell = (x_q == XW'(GRID_W - 1)) && (y_q == YW'(GRID_H - 1));
  assign cell_code = obj_code(head, body, apple, border, tint_act);
  assign col_s     = 16'(X_OFF) + 16'(x_q) * 16'(CELL_PX);
  assign col_e     = col_s + 16'(CELL_PX - 1);
  assign row_s     = 16'(Y_OFF) + 16'(y_q) * 16'(CELL_PX);
  assign row_e     = row_s + 16'(CELL_PX - 1);
  assign pix       = obj_colour(code_q, tint_act);

  always_comb begin
    state_d      = state_q;
    init_idx_d   = init_idx_q;
    wait_cnt_d   = wait_cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    full_d       = full_q;
    start_pend_d = start_pend_q;
    code_d       = code_q;
    bcnt_d       = bcnt_q;
    shadow_vld_d = shadow_vld_q;
    frame_done_d = 1'b0;
    csx_d        = csx_q;
    shadow_we    = 1'b0;
    adv          = 1'b0;
    tx_vld       = 1'b0;
    tx_dat       = 8'h00;
    tx_dcx       = 1'b1;
`ifdef T06_GAMEOVER_TINT_EN
    tint_d      = tint_q;
    tint_done_d = game_over ? tint_done_q : 1'b0;
`endif

    // A start outside IDLE is remembered so the frame in flight is not disturbed.
    if (start && (state_q != ST_IDLE)) start_pend_d = 1'b1;

    case (state_q)
      ST_INIT_SEND: begin
        tx_vld = 1'b1;
        tx_dat = ent.dat;
        tx_dcx = ent.dcx;
        if (tx_rdy) begin
          if (ent.wait_after) begin
            state_d    = ST_INIT_WAIT;
            wait_cnt_d = 32'(INIT_WAIT);
          end else if (init_idx_q == INIT_LAST) begin
            state_d = ST_SCAN;
            full_d  = 1'b1;
          end else begin
            init_idx_d = init_idx_q + 3'd1;
          end
        end
      end

      ST_INIT_WAIT: begin
        if (wait_cnt_q == 32'd0) begin
          init_idx_d = init_idx_q + 3'd1;
          state_d    = ST_INIT_SEND;
        end else begin
          wait_cnt_d = wait_cnt_q - 32'd1;
        end
      end

      ST_IDLE: begin
        if (start || start_pend_q) begin
          state_d      = ST_SCAN;
          full_d       = 1'b1;
          start_pend_d = 1'b0;
`ifdef T06_GAMEOVER_TINT_EN
        end else if (game_over && !tint_done_q) begin
          state_d = ST_SCAN;
          full_d  = 1'b1;
          tint_d  = 1'b1;
`endif
        end else if (!game_over) begin
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // x/y have been stable since the previous edge, so the flags belong to this cell.
        if (shadow_vld_q[cell_idx] && (shadow_code_q[cell_idx] == cell_code) && !full_q) begin
          adv = 1'b1;
        end else begin
          code_d  = cell_code;
          bcnt_d  = '0;
          state_d = ST_DRAW;
        end
      end

      ST_DRAW: begin
        tx_vld = 1'b1;
        case (int'(bcnt_q))
          0:  begin tx_dat = CMD_CASET; tx_dcx = 1'b0; end
          1:  tx_dat = col_s[15:8];
          2:  tx_dat = col_s[7:0];
          3:  tx_dat = col_e[15:8];
          4:  tx_dat = col_e[7:0];
          5:  begin tx_dat = CMD_PASET; tx_dcx = 1'b0; end
          6:  tx_dat = row_s[15:8];
          7:  tx_dat = row_s[7:0];
          8:  tx_dat = row_e[15:8];
          9:  tx_dat = row_e[7:0];
          10: begin tx_dat = CMD_RAMWR; tx_dcx = 1'b0; end
          // Pixel bytes start at odd index 11, so odd counts carry the MSB.
          default: tx_dat = bcnt_q[0] ? pix[15:8] : pix[7:0];
        endcase
        if (tx_rdy) begin
          if (bcnt_q == BW'(NBYTES - 1)) begin
            shadow_we              = 1'b1;
            shadow_vld_d[cell_idx] = 1'b1;
            adv                    = 1'b1;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      end

      default: state_d = ST_INIT_SEND;
    endcase

    if (adv) begin
      if (last_cell) begin
        x_d          = '0;
        y_d          = '0;
        full_d       = 1'b0;
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
`ifdef T06_GAMEOVER_TINT_EN
        // Tinted cells no longer match their stored codes; force a repaint later.
        if (tint_q) begin
          tint_d       = 1'b0;
          tint_done_d  = 1'b1;
          shadow_vld_d = '0;
        end
`endif
      end else if (x_q == XW'(GRID_W - 1)) begin
        x_d     = '0;
        y_d     = y_q + YW'(1);
        state_d = ST_SCAN;
      end else begin
        x_d     = x_q + XW'(1);
        state_d = ST_SCAN;
      end
    end

    // Chip select falls with the first byte and rises once the bus goes quiet.
    if (tx_vld && tx_rdy) csx_d = 1'b0;
    else if (tx_rdy)      csx_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT_SEND;
      init_idx_q   <= 3'd0;
      wait_cnt_q   <= 32'd0;
      x_q          <= '0;
      y_q          <= '0;
      full_q       <= 1'b0;
      start_pend_q <= 1'b0;
      code_q       <= OBJ_EMPTY;
      bcnt_q       <= '0;
      shadow_vld_q <= '0;
      frame_done_q <= 1'b0;
      csx_q        <= 1'b1;
`ifdef T06_GAMEOVER_TINT_EN
      tint_q       <= 1'b0;
      tint_done_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      init_idx_q   <= init_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      full_q       <= full_d;
      start_pend_q <= start_pend_d;
      code_q       <= code_d;
      bcnt_q       <= bcnt_d;
      shadow_vld_q <= shadow_vld_d;
      frame_done_q <= frame_done_d;
      csx_q        <= csx_d;
`ifdef T06_GAMEOVER_TINT_EN
      tint_q       <= tint_d;
      tint_done_q  <= tint_done_d;
`endif
    end
  end

  // Code storage needs no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_code_q[cell_idx] <= code_q;
  end

  t06_lcd_byte_tx #(
    .WR_LOW (WR_LOW),
    .WR_HIGH(WR_HIGH)
  ) u_byte_tx (
    .clk     (clk),
    .rst     (rst),
    .byte_dat(tx_dat),
    .byte_dcx(tx_dcx),
    .byte_vld(tx_vld),
    .byte_rdy(tx_rdy),
    .lcd_wr  (lcd_wr),
    .lcd_d   (lcd_d),
    .lcd_dcx (lcd_dcx)
  );

  assign x          = x_q;
  assign y          = y_q;
  assign lcd_csx    = csx_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_t06_lcd_frame_engine.sv
// Directed bench for the LCD frame engine on a 4x4 grid of 2x2-pixel cells.
// Latency: n/a. Backpressure: n/a.
module tb_t06_lcd_frame_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       body, head, apple, border;
  logic       start = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] x, y;
  logic       lcd_csx, lcd_dcx, lcd_wr;
  logic [7:0] lcd_d;
  logic       busy, frame_done;

  logic [15:0] head_m = '0, body_m = '0, apple_m = '0, border_m = '0;

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int csx_err = 0;
  int last_wait = 0;
  logic [8:0] bus_q [$];

  always #5 clk = ~clk;

  // Combinational cell lookup model.
  assign head   = head_m[{y, x}];
  assign body   = body_m[{y, x}];
  assign apple  = apple_m[{y, x}];
  assign border = border_m[{y, x}];

  t06_lcd_frame_engine #(
    .GRID_W(4), .GRID_H(4), .CELL_PX(2), .X_OFF(0), .Y_OFF(0),
    .WR_LOW(1), .WR_HIGH(1), .INIT_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst), .body(body), .head(head), .apple(apple), .border(border),
    .start(start), .game_over(game_over), .x(x), .y(y),
    .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx), .lcd_wr(lcd_wr), .lcd_d(lcd_d),
    .busy(busy), .frame_done(frame_done)
  );

  // Panel model: latch {dcx, data} on each write-strobe rising edge.
  always @(posedge lcd_wr) begin
    if (rst === 1'b0) begin
      bus_q.push_back({lcd_dcx, lcd_d});
      if (lcd_csx !== 1'b0) csx_err++;
    end
  end

  always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_fd(input int target, input int budget, input string tag);
    int n = 0;
    while (fd_cnt < target && n < budget) begin
      tick();
      n++;
    end
    last_wait = n;
    check(tag, 32'(fd_cnt >= target), 32'd1);
  endtask

  task automatic wait_bytes(input int target, input int budget, input string tag);
    int n = 0;
    while (bus_q.size() < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(bus_q.size() >= target), 32'd1);
  endtask

  function automatic int count_ramwr();
    int c = 0;
    foreach (bus_q[i]) if (bus_q[i] == 9'h02C) c++;
    return c;
  endfunction

  logic [8:0] init_exp [7];
  logic [8:0] cell_exp [19];
  int f0;
  int n;

  initial begin
    init_exp = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};

    // Reset state.
    ticks(3);
    check("rst_csx", lcd_csx, 1);
    check("rst_wr", lcd_wr, 1);
    check("rst_dcx", lcd_dcx, 1);
    check("rst_d", lcd_d, 0);
    check("rst_xy", {x, y}, 0);
    check("rst_busy", busy, 1);
    check("rst_frame_done", frame_done, 0);

    // Init sequence followed by the forced full first frame.
    rst = 1'b0;
    wait_fd(1, 3000, "first_frame_timeout");
    ticks(3);
    for (int i = 0; i < 7; i++) check($sformatf("init_%0d", i), bus_q[i], init_exp[i]);
    check("frame1_bytes", bus_q.size(), 7 + 16 * 19);
    check("frame1_ramwr", count_ramwr(), 16);
    check("frame1_cell0_caset", bus_q[7], 9'h02A);
    check("frame1_cell1_colstart", bus_q[28], 9'h102);
    check("frame1_cell1_colend", bus_q[30], 9'h103);
    check("frame1_done_once", fd_cnt, 1);

    // Unchanged inputs: no drawing, fast frame.
    bus_q.delete();
    wait_fd(2, 40, "frame2_timeout");
    check("frame2_fast", 32'(last_wait + 3 <= 24), 1);
    check("frame2_no_bytes", bus_q.size(), 0);

    // Head appears at (2,1).
    head_m[6] = 1'b1;
    bus_q.delete();
    f0 = fd_cnt;
    wait_fd(f0 + 2, 400, "head_timeout");
    ticks(3);
    cell_exp = '{9'h02A, 9'h100, 9'h104, 9'h100, 9'h105,
                 9'h02B, 9'h100, 9'h102, 9'h100, 9'h103, 9'h02C,
                 9'h107, 9'h1E0, 9'h107, 9'h1E0, 9'h107, 9'h1E0, 9'h107, 9'h1E0};
    check("head_bytes", bus_q.size(), 19);
    for (int i = 0; i < 19; i++) check($sformatf("head_b%0d", i), bus_q[i], cell_exp[i]);

    // Head and body together at (0,0): head colour wins.
    f0 = fd_cnt;
    wait_fd(f0 + 1, 100, "sync_timeout");
    head_m[0] = 1'b1;
    body_m[0] = 1'b1;
    bus_q.delete();
    f0 = fd_cnt;
    wait_fd(f0 + 2, 400, "prio_timeout");
    ticks(3);
    check("prio_bytes", bus_q.size(), 19);
    check("prio_colend_lo", bus_q[4], 9'h101);
    check("prio_rowend_lo", bus_q[9], 9'h101);
    check("prio_pix_hi", bus_q[11], 9'h107);
    check("prio_pix_lo", bus_q[12], 9'h1E0);

    // start pulsed mid-scan: current frame unaltered, then a full redraw.
    f0 = fd_cnt;
    wait_fd(f0 + 1, 100, "sync2_timeout");
    bus_q.delete();
    ticks(5);
    check("midscan_busy", busy, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_fd(f0 + 2, 40, "midscan_finish_timeout");
    check("midscan_frame_unaltered", bus_q.size(), 0);
    wait_fd(f0 + 3, 1200, "full_redraw_timeout");
    ticks(3);
    check("full_redraw_ramwr", count_ramwr(), 16);
    check("full_redraw_bytes", bus_q.size(), 16 * 19);

    // Reset in the middle of a pixel byte.
    bus_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_bytes(12, 400, "pixel_reach_timeout");
    n = 0;
    while (lcd_wr !== 1'b0 && n < 10) begin
      tick();
      n++;
    end
    check("pixel_wr_low", lcd_wr, 0);
    rst = 1'b1;
    tick();
    check("midrst_wr", lcd_wr, 1);
    check("midrst_csx", lcd_csx, 1);
    check("midrst_busy", busy, 1);
    tick();
    bus_q.delete();
    rst = 1'b0;
    wait_bytes(7, 300, "reinit_timeout");
    for (int i = 0; i < 7; i++) check($sformatf("reinit_%0d", i), bus_q[i], init_exp[i]);

    check("csx_low_on_every_strobe", csx_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
